bus_ctrl_fsm: RTL and testbench

- Control unit that sequences the single-bus register datapath (AR, IR, PC, DR, AC, SRAM) through fetch/decode/execute by driving its sel, load and AR_in inputs every cycle.
- Owns the program counter. The instruction is read back from datapath IR.
- Sits beside the datapath at the top level. The datapath is otherwise unchanged.

---
 rtl/bus_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_bus_ctrl_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_fsm.sv
// bus_ctrl_fsm
// Control unit for the single-bus register datapath (AR, IR, PC, DR, AC, SRAM).
// Sequences fetch / decode / execute by driving the datapath bus source
// select, the one-hot bus destination load and the AR input address every
// cycle. Owns the program counter; the current instruction is read back from
// the datapath IR.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse; leaves IDLE and begins fetching at pc
//   ir_in      datapath IR; [15:12] opcode, [7:0] operand address
//   sel        bus source: 000 AR, 001 IR, 010 PC, 011 DR, 100 AC, 101 SRAM, 111 idle
//   load       one-hot bus destination: [0] AR, [1] IR, [2] PC, [3] DR, [4] AC, [5] SRAM write
//   ar_in      address presented to AR (AR reloads from it every cycle)
//   pc         current program counter
//   busy       high in every state except IDLE and HALT
//   halted     high in HALT
//   illegal    sticky; set when an undefined opcode is decoded
//   dbg_state  current FSM state encoding
//
// Handshake: start is a level sampled only in IDLE; any cycle with start=1 in
// IDLE launches a fetch, start in any other state is ignored. There is no
// ready/valid backpressure on the datapath side: every access has a fixed
// length set by RD_LAT.
module bus_ctrl_fsm #(
  parameter int RD_LAT = 0,
  parameter int PC_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     ir_in,
  output logic [2:0]      sel,
  output logic [5:0]      load,
  output logic [PC_W-1:0] ar_in,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [3:0]      dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_WAIT  = 4'd2,
    S_F_LOAD  = 4'd3,
    S_DEC     = 4'd4,
    S_R_ADDR  = 4'd5,
    S_R_WAIT  = 4'd6,
    S_R_LOAD  = 4'd7,
    S_W_ADDR  = 4'd8,
    S_W_STORE = 4'd9,
    S_X_MAD   = 4'd10,
    S_X_MDA   = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

  localparam logic [2:0] SEL_DR   = 3'b011;
  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_SRAM = 3'b101;
  localparam logic [2:0] SEL_IDLE = 3'b111;

  localparam logic [5:0] LD_IR   = 6'b000010;
  localparam logic [5:0] LD_DR   = 6'b001000;
  localparam logic [5:0] LD_AC   = 6'b010000;
  localparam logic [5:0] LD_SRAM = 6'b100000;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_illegal;
  logic [WAIT_W-1:0] r_wait;

  logic [3:0]        w_opcode;
  logic [PC_W-1:0]   w_operand;
  logic              w_unused;

  assign w_opcode  = ir_in[15:12];
  assign w_operand = PC_W'(ir_in[7:0]);
  assign w_unused  = ^ir_in[11:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_illegal <= 1'b0;
      r_wait    <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_state <= S_F_ADDR;
        S_F_ADDR: begin
          r_wait  <= '0;
          r_state <= S_F_WAIT;
        end
        // Wait states last 1+RD_LAT cycles: the first covers the AR->addr
        // register stage, the rest cover extra SRAM latency.
        S_F_WAIT: begin
          if (r_wait == WAIT_LAST) r_state <= S_F_LOAD;
          else                     r_wait  <= r_wait + 1'b1;
        end
        S_F_LOAD: begin
          r_pc    <= r_pc + PC_W'(1);
          r_state <= S_DEC;
        end
        S_DEC: begin
          case (w_opcode)
            4'h0: r_state <= S_F_ADDR;
            4'h1: r_state <= S_R_ADDR;
            4'h2: r_state <= S_W_ADDR;
            4'h3: begin
              r_pc    <= w_operand;
              r_state <= S_F_ADDR;
            end
            4'h4: r_state <= S_X_MAD;
            4'h5: r_state <= S_X_MDA;
            4'hF: r_state <= S_HALT;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= S_HALT;
            end
          endcase
        end
        S_R_ADDR: begin
          r_wait  <= '0;
          r_state <= S_R_WAIT;
        end
        S_R_WAIT: begin
          if (r_wait == WAIT_LAST) r_state <= S_R_LOAD;
          else                     r_wait  <= r_wait + 1'b1;
        end
        S_R_LOAD:  r_state <= S_F_ADDR;
        S_W_ADDR:  r_state <= S_W_STORE;
        S_W_STORE: r_state <= S_F_ADDR;
        S_X_MAD:   r_state <= S_F_ADDR;
        S_X_MDA:   r_state <= S_F_ADDR;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the datapath controls. The operand address is driven in
  // every cycle of a data access because AR reloads from ar_in each cycle.
  always_comb begin
    sel   = SEL_IDLE;
    load  = '0;
    ar_in = r_pc;
    case (r_state)
      S_F_LOAD: begin
        sel  = SEL_SRAM;
        load = LD_IR;
      end
      S_R_ADDR, S_R_WAIT, S_W_ADDR: ar_in = w_operand;
      S_R_LOAD: begin
        ar_in = w_operand;
        sel   = SEL_SRAM;
        load  = LD_AC;
      end
      S_W_STORE: begin
        ar_in = w_operand;
        sel   = SEL_AC;
        load  = LD_SRAM;
      end
      S_X_MAD: begin
        sel  = SEL_AC;
        load = LD_DR;
      end
      S_X_MDA: begin
        sel  = SEL_DR;
        load = LD_AC;
      end
      default: ;
    endcase
  end

  assign pc        = r_pc;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_ctrl_fsm.sv
module tb_bus_ctrl_fsm;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_F_ADDR = 4'd1;
  localparam logic [3:0] ST_F_WAIT = 4'd2;
  localparam logic [3:0] ST_F_LOAD = 4'd3;
  localparam logic [3:0] ST_HALT   = 4'd12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start2 = 1'b0;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT with RD_LAT=0 and its datapath model ----------------
  logic [2:0]  d0_sel;
  logic [5:0]  d0_load;
  logic [7:0]  d0_ar, d0_pc;
  logic        d0_busy, d0_halted, d0_illegal;
  logic [3:0]  d0_st;
  logic [15:0] init0 [0:255];
  logic [15:0] mem0  [0:255];
  logic [7:0]  m0_ar, m0_addr;
  logic [15:0] m0_ir, m0_dr, m0_ac, m0_din, m0_bus;
  logic        m0_we;

  bus_ctrl_fsm #(.RD_LAT(0), .PC_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .ir_in(m0_ir),
    .sel(d0_sel), .load(d0_load), .ar_in(d0_ar), .pc(d0_pc),
    .busy(d0_busy), .halted(d0_halted), .illegal(d0_illegal), .dbg_state(d0_st)
  );

  always_comb begin
    case (d0_sel)
      3'b000:  m0_bus = {8'h00, m0_ar};
      3'b001:  m0_bus = m0_ir;
      3'b010:  m0_bus = {8'h00, d0_pc};
      3'b011:  m0_bus = m0_dr;
      3'b100:  m0_bus = m0_ac;
      3'b101:  m0_bus = mem0[m0_addr];
      default: m0_bus = 16'h0000;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0 <= init0;
      m0_ar <= 8'h00; m0_addr <= 8'h00; m0_ir <= 16'h0; m0_dr <= 16'h0;
      m0_ac <= 16'h0; m0_din <= 16'h0; m0_we <= 1'b0;
    end else begin
      m0_ar   <= d0_ar;
      m0_addr <= m0_ar;
      m0_we   <= d0_load[5];
      m0_din  <= m0_bus;
      if (m0_we)      mem0[m0_addr] <= m0_din;
      if (d0_load[1]) m0_ir <= m0_bus;
      if (d0_load[3]) m0_dr <= m0_bus;
      if (d0_load[4]) m0_ac <= m0_bus;
    end
  end

  // ---------------- DUT with RD_LAT=2 and its datapath model ----------------
  logic [2:0]  d2_sel;
  logic [5:0]  d2_load;
  logic [7:0]  d2_ar, d2_pc;
  logic        d2_busy, d2_halted, d2_illegal;
  logic [3:0]  d2_st;
  logic [15:0] init2 [0:255];
  logic [15:0] mem2  [0:255];
  logic [7:0]  m2_ar, m2_addr;
  logic [15:0] m2_ir, m2_dr, m2_ac, m2_p1, m2_p2, m2_bus;

  bus_ctrl_fsm #(.RD_LAT(2), .PC_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ir_in(m2_ir),
    .sel(d2_sel), .load(d2_load), .ar_in(d2_ar), .pc(d2_pc),
    .busy(d2_busy), .halted(d2_halted), .illegal(d2_illegal), .dbg_state(d2_st)
  );

  always_comb begin
    case (d2_sel)
      3'b011:  m2_bus = m2_dr;
      3'b100:  m2_bus = m2_ac;
      3'b101:  m2_bus = m2_p2;  // SRAM dout two cycles behind addr
      default: m2_bus = 16'h0000;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem2 <= init2;
      m2_ar <= 8'h00; m2_addr <= 8'h00; m2_ir <= 16'h0; m2_dr <= 16'h0;
      m2_ac <= 16'h0; m2_p1 <= 16'h0; m2_p2 <= 16'h0;
    end else begin
      m2_ar   <= d2_ar;
      m2_addr <= m2_ar;
      m2_p1   <= mem2[m2_addr];
      m2_p2   <= m2_p1;
      if (d2_load[1]) m2_ir <= m2_bus;
      if (d2_load[3]) m2_dr <= m2_bus;
      if (d2_load[4]) m2_ac <= m2_bus;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      init0[i] = 16'h0000;
      init2[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Returns 1 ns after the edge at which the FSM enters F_ADDR (cycle 1).
  task automatic pulse0();
    start0 = 1'b1; tick(); start0 = 1'b0;
  endtask

  task automatic pulse2();
    start2 = 1'b1; tick(); start2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_prog();
    do_reset();
    pulse0();
    tick();
    checks++; if (d0_st !== ST_F_WAIT) begin errors++; $display("FAIL pre_reset_state: got %0d exp %0d", d0_st, ST_F_WAIT); end
    #2 rst = 1'b1;
    #1;
    checks++; if (d0_sel !== 3'b111) begin errors++; $display("FAIL reset_sel: got %b exp 111", d0_sel); end
    checks++; if (d0_load !== 6'b000000) begin errors++; $display("FAIL reset_load: got %b exp 000000", d0_load); end
    checks++; if (d0_pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %0h exp 0", d0_pc); end
    checks++; if (d0_ar !== 8'h00) begin errors++; $display("FAIL reset_ar_in: got %0h exp 0", d0_ar); end
    checks++; if ({d0_busy, d0_halted, d0_illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {d0_busy, d0_halted, d0_illegal}); end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (d0_st !== ST_IDLE) begin errors++; $display("FAIL idle_hold_state: got %0d exp %0d", d0_st, ST_IDLE); end
    checks++; if ({d0_busy, d0_pc, d0_sel} !== {1'b0, 8'h00, 3'b111}) begin errors++; $display("FAIL idle_hold_outputs: got %0h exp %0h", {d0_busy, d0_pc, d0_sel}, {1'b0, 8'h00, 3'b111}); end
  endtask

  task automatic test_fetch_lda();
    logic [7:0] exp_ar [1:7];
    exp_ar = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h40, 8'h40, 8'h40};
    clear_prog();
    init0[8'h00] = 16'h1040;
    init0[8'h01] = 16'hF000;
    init0[8'h40] = 16'hBEEF;
    do_reset();
    pulse0();
    for (int c = 1; c <= 7; c++) begin
      checks++; if ($countones(d0_load) > 1) begin errors++; $display("FAIL lda_onehot c%0d: got %b exp at most one bit", c, d0_load); end
      checks++; if (d0_ar !== exp_ar[c]) begin errors++; $display("FAIL lda_ar_in c%0d: got %0h exp %0h", c, d0_ar, exp_ar[c]); end
      if (c == 3) begin
        checks++; if (m0_ir !== 16'h0000) begin errors++; $display("FAIL lda_ir_early: got %0h exp 0", m0_ir); end
      end
      if (c == 4) begin
        checks++; if (m0_ir !== 16'h1040) begin errors++; $display("FAIL lda_ir: got %0h exp 1040", m0_ir); end
        checks++; if (d0_pc !== 8'h01) begin errors++; $display("FAIL lda_pc_inc: got %0h exp 1", d0_pc); end
      end
      if (c == 7) begin
        checks++; if (m0_ac !== 16'h0000) begin errors++; $display("FAIL lda_ac_early: got %0h exp 0", m0_ac); end
      end
      tick();
    end
    checks++; if (m0_ac !== 16'hBEEF) begin errors++; $display("FAIL lda_ac: got %0h exp beef", m0_ac); end
    checks++; if (d0_st !== ST_F_ADDR) begin errors++; $display("FAIL lda_len7: got state %0d exp %0d", d0_st, ST_F_ADDR); end
    for (int k = 0; k < 20 && !d0_halted; k++) tick();
    checks++; if ({d0_halted, d0_pc} !== {1'b1, 8'h02}) begin errors++; $display("FAIL lda_halt: got %0h exp %0h", {d0_halted, d0_pc}, {1'b1, 8'h02}); end
  endtask

  task automatic test_sta_mad_mda();
    logic [7:0] exp_q [$];
    int seen_q [$];
    int we_cnt;
    // LDA 40; STA 41; MAD; LDA 42; MDA; STA 43; HLT
    clear_prog();
    init0[0] = 16'h1040; init0[1] = 16'h2041; init0[2] = 16'h4000;
    init0[3] = 16'h1042; init0[4] = 16'h5000; init0[5] = 16'h2043;
    init0[6] = 16'hF000;
    init0[8'h40] = 16'h1234; init0[8'h42] = 16'h5555;
    exp_q = '{8'd7, 8'd6, 8'd5, 8'd7, 8'd5, 8'd6};
    do_reset();
    pulse0();
    we_cnt = 0;
    for (int k = 1; k <= 100 && !d0_halted; k++) begin
      if (d0_st == ST_F_ADDR) seen_q.push_back(k);
      if (m0_we) we_cnt++;
      checks++; if ($countones(d0_load) > 1) begin errors++; $display("FAIL prog_onehot k%0d: got %b exp at most one bit", k, d0_load); end
      tick();
    end
    checks++; if (d0_halted !== 1'b1) begin errors++; $display("FAIL prog_halt_timeout: got %b exp 1", d0_halted); end
    checks++; if (mem0[8'h41] !== 16'h1234) begin errors++; $display("FAIL sta_mem41: got %0h exp 1234", mem0[8'h41]); end
    checks++; if (mem0[8'h43] !== 16'h1234) begin errors++; $display("FAIL sta_mem43: got %0h exp 1234", mem0[8'h43]); end
    checks++; if (m0_dr !== 16'h1234) begin errors++; $display("FAIL mad_dr: got %0h exp 1234", m0_dr); end
    checks++; if (m0_ac !== 16'h1234) begin errors++; $display("FAIL mda_ac: got %0h exp 1234", m0_ac); end
    checks++; if (d0_pc !== 8'h07) begin errors++; $display("FAIL prog_pc: got %0h exp 7", d0_pc); end
    checks++; if (we_cnt !== 2) begin errors++; $display("FAIL we_cycles: got %0d exp 2", we_cnt); end
    checks++; if ({d0_busy, d0_sel, d0_load} !== {1'b0, 3'b111, 6'b0}) begin errors++; $display("FAIL halt_outputs: got %0h exp %0h", {d0_busy, d0_sel, d0_load}, {1'b0, 3'b111, 6'b0}); end
    checks++; if (seen_q.size() !== 7) begin errors++; $display("FAIL instr_count: got %0d exp 7", seen_q.size()); end
    for (int i = 0; i < 6 && i + 1 < seen_q.size(); i++) begin
      checks++; if (seen_q[i+1] - seen_q[i] !== int'(exp_q[i])) begin errors++; $display("FAIL instr_len%0d: got %0d exp %0d", i, seen_q[i+1] - seen_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_jmp_wrap();
    clear_prog();
    init0[8'h00] = 16'h3080;  // JMP 80
    init0[8'h80] = 16'h30FF;  // JMP FF
    init0[8'hFF] = 16'h0000;  // NOP, pc wraps to 00
    do_reset();
    pulse0();
    repeat (4) tick();        // cycle 5
    checks++; if ({d0_st, d0_ar, d0_pc} !== {ST_F_ADDR, 8'h80, 8'h80}) begin errors++; $display("FAIL jmp80: got %0h exp %0h", {d0_st, d0_ar, d0_pc}, {ST_F_ADDR, 8'h80, 8'h80}); end
    repeat (4) tick();        // cycle 9
    checks++; if ({d0_st, d0_ar} !== {ST_F_ADDR, 8'hFF}) begin errors++; $display("FAIL jmpff: got %0h exp %0h", {d0_st, d0_ar}, {ST_F_ADDR, 8'hFF}); end
    repeat (3) tick();        // cycle 12, DEC of NOP
    checks++; if (d0_pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %0h exp 0", d0_pc); end
    tick();                   // cycle 13
    checks++; if ({d0_st, d0_ar} !== {ST_F_ADDR, 8'h00}) begin errors++; $display("FAIL wrap_fetch: got %0h exp %0h", {d0_st, d0_ar}, {ST_F_ADDR, 8'h00}); end
  endtask

  task automatic test_illegal();
    clear_prog();
    init0[8'h00] = 16'h7000;
    do_reset();
    pulse0();
    for (int k = 0; k < 20 && !d0_halted; k++) tick();
    checks++; if ({d0_illegal, d0_halted, d0_busy} !== 3'b110) begin errors++; $display("FAIL illegal_flags: got %b exp 110", {d0_illegal, d0_halted, d0_busy}); end
    checks++; if ({d0_pc, d0_sel, d0_load} !== {8'h01, 3'b111, 6'b0}) begin errors++; $display("FAIL illegal_outputs: got %0h exp %0h", {d0_pc, d0_sel, d0_load}, {8'h01, 3'b111, 6'b0}); end
    pulse0();
    repeat (5) tick();
    checks++; if ({d0_st, d0_pc, d0_busy} !== {ST_HALT, 8'h01, 1'b0}) begin errors++; $display("FAIL halt_ignores_start: got %0h exp %0h", {d0_st, d0_pc, d0_busy}, {ST_HALT, 8'h01, 1'b0}); end
    rst = 1'b1;
    #1;
    checks++; if ({d0_illegal, d0_halted, d0_st} !== {2'b00, ST_IDLE}) begin errors++; $display("FAIL illegal_clear: got %0h exp %0h", {d0_illegal, d0_halted, d0_st}, {2'b00, ST_IDLE}); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rd_lat2();
    logic [3:0] exp_st [1:11];
    logic [7:0] exp_ar [1:11];
    // Both the fetch and the operand read stretch by RD_LAT=2: 6 + 5 cycles.
    exp_st = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7};
    exp_ar = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
    clear_prog();
    init2[8'h00] = 16'h1040;
    init2[8'h01] = 16'hF000;
    init2[8'h40] = 16'hBEEF;
    do_reset();
    pulse2();
    for (int c = 1; c <= 11; c++) begin
      checks++; if (d2_st !== exp_st[c]) begin errors++; $display("FAIL lat2_state c%0d: got %0d exp %0d", c, d2_st, exp_st[c]); end
      checks++; if (d2_ar !== exp_ar[c]) begin errors++; $display("FAIL lat2_ar_in c%0d: got %0h exp %0h", c, d2_ar, exp_ar[c]); end
      checks++; if (m2_ac !== 16'h0000) begin errors++; $display("FAIL lat2_ac_early c%0d: got %0h exp 0", c, m2_ac); end
      if (c == 6) begin
        checks++; if (m2_ir !== 16'h1040) begin errors++; $display("FAIL lat2_ir: got %0h exp 1040", m2_ir); end
      end
      tick();
    end
    checks++; if ({d2_st, m2_ac} !== {ST_F_ADDR, 16'hBEEF}) begin errors++; $display("FAIL lat2_lda: got %0h exp %0h", {d2_st, m2_ac}, {ST_F_ADDR, 16'hBEEF}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_prog();
    test_reset();
    test_fetch_lda();
    test_sta_mad_mda();
    test_jmp_wrap();
    test_illegal();
    test_rd_lat2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
